// File: rtl/led_fade_driver.sv
// Six-channel LED driver: captured pattern bits light at full brightness, cleared
// bits fade out linearly on a prescaled tick, and every channel is PWM-modulated.
module led_fade_driver #(
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned FADE_DIV       = 105000,
  parameter int unsigned FADE_STEP      = 1,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] value,
  input  logic       value_valid,
  output logic [5:0] led,
  output logic       busy
);

  localparam int unsigned N_LED = 6;
  localparam int unsigned DIV_W = 24;

  localparam logic [PWM_BITS-1:0] BMAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] C_ONE    = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = BMAX - C_ONE;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [N_LED-1:0]    LED_OFF  = {N_LED{LED_ACTIVE_LOW}};

  logic [N_LED-1:0]    r_target;
  logic [PWM_BITS-1:0] r_bright [N_LED];
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DIV_W-1:0]    r_presc;
  logic [N_LED-1:0]    r_led;
  logic                r_busy;

  logic                w_tick;
  logic [N_LED-1:0]    w_target_nxt;
  logic [PWM_BITS-1:0] w_bright_nxt [N_LED];
  logic [N_LED-1:0]    w_lit;
  logic [N_LED-1:0]    w_fading;

  // Capture wins for set bits; cleared bits (old or newly captured) take the
  // saturating decrement from their pre-edge brightness on a tick.
  always_comb begin
    w_tick       = (r_presc == DIV_LAST);
    w_target_nxt = value_valid ? value : r_target;
    w_lit        = '0;
    w_fading     = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      w_bright_nxt[i] = r_bright[i];
      w_lit[i]        = (r_bright[i] > r_pwm_cnt);
      w_fading[i]     = !r_target[i] && (r_bright[i] != '0);
      if (value_valid && value[i]) begin
        w_bright_nxt[i] = BMAX;
      end else if (w_tick && !w_target_nxt[i]) begin
        w_bright_nxt[i] = (r_bright[i] > STEP) ? (r_bright[i] - STEP) : '0;
      end
    end
  end

  // State, counters and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target  <= '0;
      r_pwm_cnt <= '0;
      r_presc   <= '0;
      r_led     <= LED_OFF;
      r_busy    <= 1'b0;
      for (int i = 0; i < int'(N_LED); i++) begin
        r_bright[i] <= '0;
      end
    end else begin
      r_target  <= w_target_nxt;
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : (r_pwm_cnt + C_ONE);
      r_presc   <= w_tick ? '0 : (r_presc + DIV_ONE);
      r_led     <= w_lit ^ LED_OFF;
      r_busy    <= |w_fading;
      for (int i = 0; i < int'(N_LED); i++) begin
        r_bright[i] <= w_bright_nxt[i];
      end
    end
  end

  assign led  = r_led;
  assign busy = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: three instances (step 51/100/153) share stimulus and
// are compared every cycle against an integer model, plus directed vectors.
module tb_led_fade_driver;

  localparam int NI   = 3;
  localparam int BMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] value;
  logic       value_valid;
  logic [5:0] led_a, led_b, led_c;
  logic       busy_a, busy_b, busy_c;

  led_fade_driver #(.PWM_BITS(8), .FADE_DIV(4), .FADE_STEP(51), .LED_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .led(led_a), .busy(busy_a));
  led_fade_driver #(.PWM_BITS(8), .FADE_DIV(4), .FADE_STEP(100), .LED_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .led(led_b), .busy(busy_b));
  led_fade_driver #(.PWM_BITS(8), .FADE_DIV(1000), .FADE_STEP(153), .LED_ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .led(led_c), .busy(busy_c));

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  int         m_k;
  int         m_b [NI][6];
  logic [5:0] m_t;

  typedef struct {
    logic [5:0] v;
    logic       vv;
    logic [5:0] la;
    logic       ba;
    logic [5:0] lb;
    logic       bb;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_of(input int n);
    case (n)
      0:       return 51;
      1:       return 100;
      default: return 153;
    endcase
  endfunction

  function automatic int div_of(input int n);
    return (n == 2) ? 1000 : 4;
  endfunction

  function automatic int dut_led(input int n);
    case (n)
      0:       return int'(led_a);
      1:       return int'(led_b);
      default: return int'(led_c);
    endcase
  endfunction

  function automatic int dut_busy(input int n);
    case (n)
      0:       return int'(busy_a);
      1:       return int'(busy_b);
      default: return int'(busy_c);
    endcase
  endfunction

  // Expected pins one edge later: lit iff brightness exceeds the PWM phase.
  function automatic logic [5:0] m_led(input int n);
    logic [5:0] r;
    r = '1;
    for (int i = 0; i < 6; i++)
      if (m_b[n][i] > (m_k % BMAX)) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic m_busy(input int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 6; i++)
      if (!m_t[i] && m_b[n][i] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_t = '0;
    for (int n = 0; n < NI; n++)
      for (int i = 0; i < 6; i++) m_b[n][i] = 0;
  endtask

  // One clock: drive inputs, advance model, compare all instances after the edge.
  task automatic cycle(input logic [5:0] v, input logic vv);
    logic [5:0] el [NI];
    logic       eb [NI];
    bit         tick;
    bit         tgt;
    value       = v;
    value_valid = vv;
    for (int n = 0; n < NI; n++) begin
      el[n] = m_led(n);
      eb[n] = m_busy(n);
      tick  = (m_k % div_of(n)) == (div_of(n) - 1);
      for (int i = 0; i < 6; i++) begin
        tgt = vv ? v[i] : m_t[i];
        if (vv && v[i]) m_b[n][i] = BMAX;
        else if (tick && !tgt) m_b[n][i] = (m_b[n][i] > step_of(n)) ? m_b[n][i] - step_of(n) : 0;
      end
    end
    if (vv) m_t = v;
    m_k++;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    for (int n = 0; n < NI; n++) begin
      chk($sformatf("model_led%0d k=%0d", n, m_k), dut_led(n), int'(el[n]));
      chk($sformatf("model_busy%0d k=%0d", n, m_k), dut_busy(n), int'(eb[n]));
    end
  endtask

  task automatic run_table(input string tag);
    for (int e = 0; e < 22; e++) begin
      cycle(tbl[e].v, tbl[e].vv);
      chk($sformatf("%s_led_a e%0d", tag, e + 1), int'(led_a), int'(tbl[e].la));
      chk($sformatf("%s_busy_a e%0d", tag, e + 1), int'(busy_a), int'(tbl[e].ba));
      chk($sformatf("%s_led_b e%0d", tag, e + 1), int'(led_b), int'(tbl[e].lb));
      chk($sformatf("%s_busy_b e%0d", tag, e + 1), int'(busy_b), int'(tbl[e].bb));
    end
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_led_a"}, int'(led_a), 'h3F);
    chk({tag, "_led_b"}, int'(led_b), 'h3F);
    chk({tag, "_led_c"}, int'(led_c), 'h3F);
    chk({tag, "_busy"}, int'({busy_a, busy_b, busy_c}), 0);
  endtask

  initial begin
    int cnt_duty, cnt_full, cnt_busy;

    // Capture LED0, clear it, then set LED1 exactly on the third tick edge (e12).
    tbl[0] = '{6'h01, 1'b1, 6'h3F, 1'b0, 6'h3F, 1'b0};
    tbl[1] = '{6'h00, 1'b0, 6'h3E, 1'b0, 6'h3E, 1'b0};
    tbl[2] = '{6'h00, 1'b1, 6'h3E, 1'b0, 6'h3E, 1'b0};
    for (int e = 3; e < 11; e++) tbl[e] = '{6'h00, 1'b0, 6'h3E, 1'b1, 6'h3E, 1'b1};
    tbl[11] = '{6'h02, 1'b1, 6'h3E, 1'b1, 6'h3E, 1'b1};
    for (int e = 12; e < 20; e++) tbl[e] = '{6'h00, 1'b0, 6'h3C, 1'b1, 6'h3D, 1'b0};
    for (int e = 20; e < 22; e++) tbl[e] = '{6'h00, 1'b0, 6'h3D, 1'b0, 6'h3D, 1'b0};

    rst_n       = 1'b1;
    value       = '0;
    value_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_pins("por");
    repeat (3) @(negedge clk);
    check_reset_pins("por_held");
    rst_n = 1'b1;
    model_reset();

    run_table("tbl");

    // LED0 of u_c sits at 102 between its ticks at edges 1000 and 2000.
    while (m_k < 1100) cycle(6'h00, 1'b0);
    cnt_duty = 0;
    cnt_full = 0;
    cnt_busy = 0;
    for (int c = 0; c < 255; c++) begin
      cycle(6'h00, 1'b0);
      if (led_c[0] == 1'b0) cnt_duty++;
      if (led_a == 6'h3D && !busy_a) cnt_full++;
      if (busy_c) cnt_busy++;
    end
    chk("duty_c_102", cnt_duty, 102);
    chk("fullon_a_255", cnt_full, 255);
    chk("busy_c_window", cnt_busy, 255);

    // Reset in the middle of a fade and a PWM period.
    cycle(6'h3F, 1'b1);
    cycle(6'h00, 1'b1);
    repeat (7) cycle(6'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_pins("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_pins("rst_held");
    rst_n = 1'b1;
    model_reset();

    run_table("post_rst");

    for (int c = 0; c < 3000; c++)
      cycle(6'($urandom), ($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set brightness and PWM counter width; the maximum brightness is BMAX = 2^PWM_BITS-1.
REQ-002 Parameter FADE_DIV, default 105000, SHALL set the clk cycles per fade tick (range 1 to 2^24-1).
REQ-003 Parameter FADE_STEP, default 1, SHALL set the brightness decrement per fade tick (range 1 to BMAX).
REQ-004 Parameter LED_ACTIVE_LOW, default 1, SHALL be 1 when a lit LED is driven 0 and 0 when a lit LED is driven 1.
REQ-005 clk  input  1  system clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 value  input  6  LED pattern from the upstream counter; bit i=1 requests LED i lit.
REQ-008 value_valid  input  1  single-cycle strobe; value is sampled when high.
REQ-009 led  output  6  PWM-modulated LED pins, polarity per LED_ACTIVE_LOW.
REQ-010 busy  output  1  high while any LED is fading.

Function
REQ-011 The block SHALL hold a 6-bit target register, six PWM_BITS-wide brightness registers bright[i], a PWM counter pwm_cnt and a fade prescaler.
REQ-012 pwm_cnt SHALL count 0..BMAX-1 and wrap to 0, giving a period of BMAX cycles.
REQ-013 LED i SHALL be lit in a cycle iff bright[i] > pwm_cnt: bright=0 is always off and bright=BMAX is always on.
REQ-014 The prescaler SHALL count 0..FADE_DIV-1 and wrap, asserting an internal tick in the cycle it equals FADE_DIV-1; FADE_DIV=1 ticks every cycle.
REQ-015 On value_valid, target SHALL load value at that edge; for each bit with value[i]=1, bright[i] SHALL become BMAX at the same edge.
REQ-016 On a tick edge, each LED with target[i]=0 and bright[i]>0 SHALL take bright[i] <= max(bright[i]-FADE_STEP, 0), computed without wrap-around.
REQ-017 When value_valid and a tick occur together, REQ-015 SHALL take precedence for bits with value[i]=1.
REQ-018 For those same simultaneous events, bits with value[i]=0 SHALL apply the decrement of REQ-016 to their pre-edge brightness.
REQ-019 Per-LED states SHALL be OFF (target=0, bright=0), ON (target=1), and FADING (target=0, bright>0).
REQ-020 State transitions: OFF/FADING->ON on capture with bit=1; ON->FADING on capture with bit=0; FADING->OFF when the saturating decrement reaches 0; ON->ON on a re-capture with bit=1, which holds BMAX.
REQ-021 led SHALL be registered: value_valid sampled at edge N SHALL appear on led at edge N+1, with PWM gating applied.
REQ-022 busy SHALL be a registered OR over i of (target[i]=0 AND bright[i]>0), with the same one-cycle latency as led.
REQ-023 value SHALL be ignored when value_valid=0; target and bright SHALL change only per REQ-015 through REQ-018.

Reset
REQ-024 While rst_n=0, and asynchronously on its assertion, target, bright[*], pwm_cnt and the prescaler SHALL be 0, and busy SHALL be 0.
REQ-025 While rst_n=0, and asynchronously on its assertion, led SHALL be all-off: 6'b111111 when LED_ACTIVE_LOW=1, else 6'b000000.
REQ-026 Reset asserted mid-fade or mid-PWM-period SHALL abort all activity with no residual state.
REQ-027 After rst_n deasserts, the first counting edge SHALL set pwm_cnt and the prescaler to 1.

Verification (PWM_BITS=8, FADE_DIV=4, FADE_STEP=51, LED_ACTIVE_LOW=1)
REQ-028 Reset check: assert rst_n=0 mid-run -> led=6'b111111 and busy=0 immediately, with no clock needed.
REQ-029 Full-on check: value=6'b000001 with a 1-cycle strobe -> led[0]=0 for all 255 cycles of a PWM period, led[5:1]=1, busy=0.
REQ-030 Fade check: 6'b000001 then 6'b000000 -> bright[0] steps 255,204,153,102,51,0 on successive ticks, 4 cycles apart; busy is high until 0 is reached, then low.
REQ-031 Duty check: with bright[0] held at 102, led[0]=0 for exactly 102 of 255 cycles per period.
REQ-032 Simultaneous-event check: value_valid on a tick cycle with value=6'b000010 while LED0 is fading at 153 -> bright[1]=255 and bright[0]=102 after the same edge.
REQ-033 Saturation check: FADE_STEP=100 and a fade from 255 -> bright steps 155, 55, 0 and never wraps.
